// File: rtl/ex_pkg.sv
// Shared op, pcsrc and state encodings for the execute lanes.
// Optional multiplier enabled by EX_LANES_MUL_EN.
package ex_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_SLTU = 4'h6;
  localparam logic [3:0] OP_SLL  = 4'h7;
  localparam logic [3:0] OP_SRL  = 4'h8;
  localparam logic [3:0] OP_SRA  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;

  localparam logic [1:0] PC_NONE = 2'b00;
  localparam logic [1:0] PC_BEQ  = 2'b01;
  localparam logic [1:0] PC_J    = 2'b10;
  localparam logic [1:0] PC_BNE  = 2'b11;

  typedef enum logic [1:0] {
    S_EMPTY    = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_FULL     = 2'd2
  } state_t;

endpackage

// File: rtl/ex_alu.sv
// Single-lane ALU with branch compare and target generation.
// MUL result only when EX_LANES_MUL_EN is defined.
module ex_alu
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [25:0]     i_imm,
  input  logic            i_bsel,
  input  logic [XLEN-1:0] i_pc,
  input  logic [1:0]      i_pcsrc,
  output logic [XLEN-1:0] o_res,
  output logic            o_taken,
  output logic [XLEN-1:0] o_target
);

  logic [XLEN-1:0] w_sext;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_boff;
  logic [XLEN-1:0] w_jtgt;
  logic [4:0]      w_sh;

  assign w_sext = {{(XLEN-16){i_imm[15]}}, i_imm[15:0]};
  assign w_b    = i_bsel ? w_sext : i_b;
  assign w_sh   = w_b[4:0];
  assign w_boff = {w_sext[XLEN-3:0], 2'b00};
  assign w_jtgt = {i_pc[XLEN-1:28], i_imm, 2'b00};

  always_comb begin
    o_res = '0;
    case (i_op)
      OP_ADD:  o_res = i_a + w_b;
      OP_SUB:  o_res = i_a - w_b;
      OP_AND:  o_res = i_a & w_b;
      OP_OR:   o_res = i_a | w_b;
      OP_XOR:  o_res = i_a ^ w_b;
      OP_SLT:  o_res = {{(XLEN-1){1'b0}},
                        $signed(i_a) < $signed(w_b)};
      OP_SLTU: o_res = {{(XLEN-1){1'b0}}, i_a < w_b};
      OP_SLL:  o_res = i_a << w_sh;
      OP_SRL:  o_res = i_a >> w_sh;
      OP_SRA:  o_res = $signed(i_a) >>> w_sh;
`ifdef EX_LANES_MUL_EN
      OP_MUL:  o_res = i_a * w_b;
`endif
      default: o_res = '0;
    endcase
  end

  // Compare uses the register operand; the immediate is the offset.
  always_comb begin
    o_taken  = 1'b0;
    o_target = '0;
    case (i_pcsrc)
      PC_BEQ: begin
        o_taken  = (i_a == i_b);
        o_target = i_pc + w_boff;
      end
      PC_BNE: begin
        o_taken  = (i_a != i_b);
        o_target = i_pc + w_boff;
      end
      PC_J: begin
        o_taken  = 1'b1;
        o_target = w_jtgt;
      end
      default: begin
        o_taken  = 1'b0;
        o_target = '0;
      end
    endcase
  end

endmodule

// File: rtl/ex_lanes.sv
// Multi-lane execute stage: ALU lanes, branch kill, redirect pulse.
// Multiply latency path enabled by EX_LANES_MUL_EN.
module ex_lanes
  import ex_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES-1:0]      in_lane_v,
  input  logic [4*LANES-1:0]    in_op,
  input  logic [XLEN*LANES-1:0] in_a,
  input  logic [XLEN*LANES-1:0] in_b,
  input  logic [26*LANES-1:0]   in_imm,
  input  logic [LANES-1:0]      in_bsel,
  input  logic [XLEN*LANES-1:0] in_pc,
  input  logic [2*LANES-1:0]    in_pcsrc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      out_lane_v,
  output logic [XLEN*LANES-1:0] out_res,
  output logic                  redirect,
  output logic [XLEN-1:0]       redirect_pc
);

  localparam int CW = $clog2(MUL_LAT + 1);

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]         r_cnt;
  logic [LANES-1:0]      r_lane_v;
  logic [XLEN*LANES-1:0] r_res;
  logic                  r_redir;
  logic [XLEN-1:0]       r_tgt;

  logic [LANES-1:0]      w_lane_v;
  logic [LANES-1:0]      w_taken;
  logic [XLEN*LANES-1:0] w_res;
  logic [XLEN*LANES-1:0] w_tgt;
  logic                  w_redir;
  logic [XLEN-1:0]       w_win_tgt;
  logic                  w_has_mul;
  logic                  w_fire;
  logic                  w_redir_fire;
  logic                  w_cap;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    ex_alu #(.XLEN(XLEN)) u_alu (
      .i_op     (in_op[4*g +: 4]),
      .i_a      (in_a[XLEN*g +: XLEN]),
      .i_b      (in_b[XLEN*g +: XLEN]),
      .i_imm    (in_imm[26*g +: 26]),
      .i_bsel   (in_bsel[g]),
      .i_pc     (in_pc[XLEN*g +: XLEN]),
      .i_pcsrc  (in_pcsrc[2*g +: 2]),
      .o_res    (w_res[XLEN*g +: XLEN]),
      .o_taken  (w_taken[g]),
      .o_target (w_tgt[XLEN*g +: XLEN])
    );
  end

`ifdef EX_LANES_MUL_EN
  always_comb begin
    w_has_mul = 1'b0;
    for (int i = 0; i < LANES; i++)
      if (in_lane_v[i] && in_op[4*i +: 4] == OP_MUL)
        w_has_mul = 1'b1;
  end
`else
  assign w_has_mul = 1'b0;
`endif

  // Oldest taken branch wins; younger lanes are wrong-path.
  always_comb begin
    w_lane_v  = in_lane_v;
    w_redir   = 1'b0;
    w_win_tgt = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_redir) begin
        w_lane_v[i] = 1'b0;
      end else if (in_lane_v[i] && w_taken[i]) begin
        w_redir   = 1'b1;
        w_win_tgt = w_tgt[XLEN*i +: XLEN];
      end
    end
  end

  assign w_fire       = (r_state == S_FULL) && out_ready;
  assign w_redir_fire = w_fire && r_redir;
  assign w_cap        = in_valid && in_ready && !w_redir_fire;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_EMPTY;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_EMPTY: begin
        if (w_cap)
          w_next = w_has_mul ? S_MUL_WAIT : S_FULL;
      end
      S_MUL_WAIT: begin
        if (r_cnt == CW'(1)) w_next = S_FULL;
      end
      S_FULL: begin
        if (w_cap)
          w_next = w_has_mul ? S_MUL_WAIT : S_FULL;
        else if (out_ready)
          w_next = S_EMPTY;
      end
      default: w_next = S_EMPTY;
    endcase
  end

  always_comb begin
    in_ready    = (r_state == S_EMPTY) ||
                  ((r_state == S_FULL) && out_ready);
    out_valid   = (r_state == S_FULL);
    redirect    = w_redir_fire;
    redirect_pc = w_redir_fire ? r_tgt : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt    <= '0;
      r_lane_v <= '0;
      r_res    <= '0;
      r_redir  <= 1'b0;
      r_tgt    <= '0;
    end else if (w_cap) begin
      r_lane_v <= w_lane_v;
      r_res    <= w_res;
      r_redir  <= w_redir;
      r_tgt    <= w_win_tgt;
      r_cnt    <= w_has_mul ? CW'(MUL_LAT - 1) : '0;
    end else if (r_state == S_MUL_WAIT) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign out_lane_v = r_lane_v;
  assign out_res    = r_res;

endmodule

// File: tb/tb_ex_lanes.sv
// Scoreboard bench for ex_lanes: directed cases plus random bundles.
// MUL checks follow EX_LANES_MUL_EN.
module tb_ex_lanes;

  localparam int LANES   = 2;
  localparam int XLEN    = 32;
  localparam int MUL_LAT = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_lane_v;
  logic [7:0]  in_op;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [51:0] in_imm;
  logic [1:0]  in_bsel;
  logic [63:0] in_pc;
  logic [3:0]  in_pcsrc;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_lane_v;
  logic [63:0] out_res;
  logic        redirect;
  logic [31:0] redirect_pc;

  ex_lanes #(.LANES(LANES), .XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_v(in_lane_v), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
    .in_bsel(in_bsel), .in_pc(in_pc), .in_pcsrc(in_pcsrc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_v(out_lane_v), .out_res(out_res),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  lv;
    logic [1:0]  vmask;
    logic [63:0] res;
    logic        rd;
    logic [31:0] rpc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  exp_t last;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;
  bit   rnd_mode = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << sh;
      4'd8: return a >> sh;
      4'd9: return 32'($signed(a) >>> sh);
`ifdef EX_LANES_MUL_EN
      4'd10: return 32'(64'(a) * 64'(b));
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t model();
    exp_t e;
    e.lv = in_lane_v;
    e.vmask = in_lane_v;
    e.res = '0;
    e.rd = 1'b0;
    e.rpc = '0;
    for (int i = 0; i < 2; i++) begin
      logic [31:0] a, b, pc, off, be, tgt;
      logic [25:0] im;
      logic tk;
      a  = in_a[32*i +: 32];
      b  = in_b[32*i +: 32];
      pc = in_pc[32*i +: 32];
      im = in_imm[26*i +: 26];
      off = 32'($signed(im[15:0])) * 4;
      be = in_bsel[i] ? 32'($signed(im[15:0])) : b;
      e.res[32*i +: 32] = ref_alu(in_op[4*i +: 4], a, be);
      tk = 1'b0;
      tgt = '0;
      case (in_pcsrc[2*i +: 2])
        2'b01: begin tk = (a == b); tgt = pc + off; end
        2'b11: begin tk = (a != b); tgt = pc + off; end
        2'b10: begin tk = 1'b1; tgt = {pc[31:28], im, 2'b00}; end
        default: tk = 1'b0;
      endcase
      if (e.rd) e.lv[i] = 1'b0;
      else if (in_lane_v[i] && tk) begin
        e.rd = 1'b1;
        e.rpc = tgt;
      end
    end
    return e;
  endfunction

  always @(negedge CLK) begin
    if (!RST && mon_en) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_output: got out_valid=1 expected none");
        end else begin
          mon_e = q.pop_front();
          chk("out_lane_v", 64'(out_lane_v), 64'(mon_e.lv));
          for (int i = 0; i < 2; i++)
            if (mon_e.vmask[i])
              chk("out_res", 64'(out_res[32*i +: 32]),
                  64'(mon_e.res[32*i +: 32]));
          chk("redirect", 64'(redirect), 64'(mon_e.rd));
          chk("redirect_pc", 64'(redirect_pc), 64'(mon_e.rpc));
        end
      end else begin
        chk("idle_redirect", {31'd0, redirect, redirect_pc}, 64'd0);
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic set_lane(input int i, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [25:0] imm, input logic bsel,
                          input logic [31:0] pc, input logic [1:0] src);
    in_op[4*i +: 4]    = op;
    in_a[32*i +: 32]   = a;
    in_b[32*i +: 32]   = b;
    in_imm[26*i +: 26] = imm;
    in_bsel[i]         = bsel;
    in_pc[32*i +: 32]  = pc;
    in_pcsrc[2*i +: 2] = src;
  endtask

  task automatic set_rand();
    in_lane_v = 2'($urandom_range(0, 3));
    for (int i = 0; i < 2; i++) begin
      int r;
      logic [1:0] src;
      logic [31:0] a, b;
      r = int'($urandom_range(0, 9));
      src = (r < 6) ? 2'b00 : (r == 7) ? 2'b10 :
            (r == 8) ? 2'b11 : 2'b01;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (r == 9) b = a;
      set_lane(i, 4'($urandom_range(0, 11)), a, b, 26'($urandom),
               (src[0]) ? 1'b0 : 1'($urandom_range(0, 1)),
               $urandom & 32'hFFFF_FFFC, src);
    end
  endtask

  task automatic send(input bit push);
    int k;
    in_valid = 1'b1;
    k = 0;
    @(negedge CLK);
    while (!in_ready && k < 200) begin
      @(negedge CLK);
      k++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end else if (push) begin
      last = model();
      q.push_back(last);
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 500) begin
      @(negedge CLK);
      k++;
    end
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    in_valid = 0; in_lane_v = 0; in_op = 0; in_a = 0; in_b = 0;
    in_imm = 0; in_bsel = 0; in_pc = 0; in_pcsrc = 0; out_ready = 0;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_lane_v", 64'(out_lane_v), 64'd0);
    chk("rst_res", out_res, 64'd0);
    chk("rst_redirect", {31'd0, redirect, redirect_pc}, 64'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    mon_en = 1'b1;

    // two-lane add/sub, one-cycle latency
    out_ready = 1'b1;
    in_lane_v = 2'b11;
    set_lane(0, 4'd0, 32'd5, 32'd7, 26'd0, 1'b0, 32'd0, 2'b00);
    set_lane(1, 4'd1, 32'd3, 32'd9, 26'd0, 1'b0, 32'd0, 2'b00);
    send(1);
    @(negedge CLK);
    chk("addsub_valid", 64'(out_valid), 64'd1);
    chk("addsub_res", out_res, 64'hFFFF_FFFA_0000_000C);
    @(posedge CLK);
    #1;

    // beq taken in lane0 kills lane1
    set_lane(0, 4'd0, 32'd4, 32'd4, 26'd3, 1'b0, 32'h100, 2'b01);
    set_lane(1, 4'd0, 32'd1, 32'd2, 26'd0, 1'b0, 32'h104, 2'b00);
    send(1);
    wait_drain();

    // jump in lane1, lane0 survives
    set_lane(0, 4'd0, 32'd10, 32'd20, 26'd0, 1'b0, 32'h8000_0000, 2'b00);
    set_lane(1, 4'd0, 32'd1, 32'd1, 26'h40, 1'b0, 32'h8000_0004, 2'b10);
    send(1);
    wait_drain();

    // stall with redirect pending, then drop the wrong-path bundle
    out_ready = 1'b0;
    set_lane(0, 4'd4, 32'd1, 32'd2, 26'h0FFFF, 1'b0, 32'h200, 2'b11);
    set_lane(1, 4'd0, 32'd6, 32'd6, 26'd0, 1'b0, 32'h204, 2'b00);
    send(1);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_res", out_res, last.res);
      @(posedge CLK);
      #1;
      if (c == 0) begin
        set_lane(0, 4'd0, 32'd9, 32'd9, 26'd0, 1'b0, 32'h300, 2'b00);
        in_valid = 1'b1;
      end
    end
    out_ready = 1'b1;
    @(negedge CLK);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    @(negedge CLK);
    chk("drop_valid", 64'(out_valid), 64'd0);
    chk("drop_in_ready", 64'(in_ready), 64'd1);
    @(posedge CLK);
    #1;

`ifdef EX_LANES_MUL_EN
    in_lane_v = 2'b01;
    set_lane(0, 4'd10, 32'd6, 32'd7, 26'd0, 1'b0, 32'd0, 2'b00);
    set_lane(1, 4'd0, 32'd0, 32'd0, 26'd0, 1'b0, 32'd0, 2'b00);
    send(1);
    for (int c = 0; c < MUL_LAT - 1; c++) begin
      @(negedge CLK);
      chk("mul_wait_valid", 64'(out_valid), 64'd0);
      chk("mul_wait_in_ready", 64'(in_ready), 64'd0);
      @(posedge CLK);
      #1;
    end
    @(negedge CLK);
    chk("mul_done_valid", 64'(out_valid), 64'd1);
    @(posedge CLK);
    #1;
`endif

    // reset right after a multiply bundle is captured
    in_lane_v = 2'b01;
    set_lane(0, 4'd10, 32'd3, 32'd5, 26'd0, 1'b0, 32'd0, 2'b00);
    send(0);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    @(posedge CLK);
    #1;

    rnd_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      set_rand();
      send(1);
      if (last.rd) wait_drain();
    end
    rnd_mode = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    chk("final_drain", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
